// File: rtl/online_pkg.sv
// Shared definitions for the radix-2 signed-digit on-line adder and its sequencer.
package online_pkg;

  localparam int unsigned ADDER_LAT = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

  // Signed digit: value = plus - minus.
  typedef struct packed {
    logic plus;
    logic minus;
  } sd_digit_t;

  localparam sd_digit_t SD_ZERO = '{plus: 1'b0, minus: 1'b0};

endpackage

// File: rtl/sd_shift_reg.sv
// Signed-digit operand register: parallel load, MSB-first serial out, zero fill.
module sd_shift_reg
  import online_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic [W-1:0] plus_vec_i,
  input  logic [W-1:0] minus_vec_i,
  output sd_digit_t    digit_o
);

  logic [W-1:0] plus_q, plus_d;
  logic [W-1:0] minus_q, minus_d;

  always_comb begin
    plus_d  = plus_q;
    minus_d = minus_q;
    if (load_i) begin
      plus_d  = plus_vec_i;
      minus_d = minus_vec_i;
    end else if (shift_i) begin
      plus_d  = plus_q << 1;
      minus_d = minus_q << 1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      plus_q  <= '0;
      minus_q <= '0;
    end else begin
      plus_q  <= plus_d;
      minus_q <= minus_d;
    end
  end

  assign digit_o = '{plus: plus_q[W-1], minus: minus_q[W-1]};

endmodule

// File: rtl/online_adder_seq_ctrl.sv
// Sequencer for the radix-2 SD on-line adder: latch operands, flush the adder,
// stream digits MSB-first with zero padding, and capture the N+1 result digits.
module online_adder_seq_ctrl
  import online_pkg::*;
#(
  parameter int unsigned N   = 8,
  parameter int unsigned LAT = ADDER_LAT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] x_plus_vec,
  input  logic [N-1:0] x_minus_vec,
  input  logic [N-1:0] y_plus_vec,
  input  logic [N-1:0] y_minus_vec,
  output logic         add_x_plus,
  output logic         add_x_minus,
  output logic         add_y_plus,
  output logic         add_y_minus,
  input  logic [1:0]   add_z,
  output logic         busy,
  output logic         done,
  output logic [N:0]   res_z1_vec,
  output logic [N:0]   res_z0_vec
);

  // One counter spans the whole busy window: FLUSH is 0..LAT-1, RUN cycle c is LAT+c.
  localparam int unsigned CNT_W = $clog2(2 * LAT + N + 2);
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(LAT - 1);
  localparam logic [CNT_W-1:0] FEED_LAST  = CNT_W'(LAT + N - 2);
  localparam logic [CNT_W-1:0] CAP_FIRST  = CNT_W'(2 * LAT);
  localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(2 * LAT + N);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  sd_digit_t        add_x_q, add_x_d;
  sd_digit_t        add_y_q, add_y_d;
  logic [N:0]       res_z1_q, res_z1_d;
  logic [N:0]       res_z0_q, res_z0_d;

  sd_digit_t        x_dig, y_dig;
  logic             load_c, feed_c, cap_c;

  assign load_c = (state_q == IDLE) && start;
  // Register the next operand digit so it is on add_* during the following cycle.
  assign feed_c = ((state_q == FLUSH) && (cnt_q == FLUSH_LAST)) ||
                  ((state_q == RUN) && (cnt_q <= FEED_LAST));
  assign cap_c  = (state_q == RUN) && (cnt_q >= CAP_FIRST);

  sd_shift_reg #(.W(N)) u_x_sr (
    .clk         (clk),
    .rst         (rst),
    .load_i      (load_c),
    .shift_i     (feed_c),
    .plus_vec_i  (x_plus_vec),
    .minus_vec_i (x_minus_vec),
    .digit_o     (x_dig)
  );

  sd_shift_reg #(.W(N)) u_y_sr (
    .clk         (clk),
    .rst         (rst),
    .load_i      (load_c),
    .shift_i     (feed_c),
    .plus_vec_i  (y_plus_vec),
    .minus_vec_i (y_minus_vec),
    .digit_o     (y_dig)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = FLUSH;
      FLUSH:   if (cnt_q == FLUSH_LAST) state_d = RUN;
      RUN:     if (cnt_q == RUN_LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d    = '0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    add_x_d  = SD_ZERO;
    add_y_d  = SD_ZERO;
    res_z1_d = res_z1_q;
    res_z0_d = res_z0_q;
    if (((state_q == FLUSH) || (state_q == RUN)) && (state_d != DONE)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    busy_d = (state_d == FLUSH) || (state_d == RUN);
    done_d = (state_d == DONE);
    if (feed_c) begin
      add_x_d = x_dig;
      add_y_d = y_dig;
    end
    if (cap_c) begin
      res_z1_d = {res_z1_q[N-1:0], add_z[1]};
      res_z0_d = {res_z0_q[N-1:0], add_z[0]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      add_x_q  <= SD_ZERO;
      add_y_q  <= SD_ZERO;
      res_z1_q <= '0;
      res_z0_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      add_x_q  <= add_x_d;
      add_y_q  <= add_y_d;
      res_z1_q <= res_z1_d;
      res_z0_q <= res_z0_d;
    end
  end

  assign add_x_plus  = add_x_q.plus;
  assign add_x_minus = add_x_q.minus;
  assign add_y_plus  = add_y_q.plus;
  assign add_y_minus = add_y_q.minus;
  assign busy        = busy_q;
  assign done        = done_q;
  assign res_z1_vec  = res_z1_q;
  assign res_z0_vec  = res_z0_q;

endmodule

// File: tb/tb_online_adder_seq_ctrl.sv
// Bench for online_adder_seq_ctrl with a behavioural on-line adder (delay 2, LAT 3)
// and a queue of expected results built from the operands at each start.
`timescale 1ns/1ps
module tb_online_adder_seq_ctrl;
  import online_pkg::*;

  localparam int N        = 8;
  localparam int LAT      = 3;
  localparam int BUSY_EXP = 2 * LAT + N + 1;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] xp = '0, xm = '0, yp = '0, ym = '0;
  logic         axp, axm, ayp, aym;
  logic [1:0]   add_z;
  logic         busy, done;
  logic [N:0]   rz1, rz0;

  int n_checks = 0;
  int n_fail   = 0;

  online_adder_seq_ctrl #(.N(N), .LAT(LAT)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .x_plus_vec  (xp),
    .x_minus_vec (xm),
    .y_plus_vec  (yp),
    .y_minus_vec (ym),
    .add_x_plus  (axp),
    .add_x_minus (axm),
    .add_y_plus  (ayp),
    .add_y_minus (aym),
    .add_z       (add_z),
    .busy        (busy),
    .done        (done),
    .res_z1_vec  (rz1),
    .res_z0_vec  (rz0)
  );

  always #5 clk = ~clk;

  function automatic int sd(input logic p, input logic m);
    return int'(p) - int'(m);
  endfunction

  // Residual r stays in [-2,2]; an output digit is emitted when |2r+s| >= 3.
  function automatic int sel_digit(input int rp);
    if (rp >= 3) return 1;
    if (rp <= -3) return -1;
    return 0;
  endfunction

  // Adder model: unreset registers start from legal but nonzero garbage.
  int         ad_s_q = -1;
  int         ad_r_q = 2;
  logic [1:0] ad_z_q = 2'b11;
  assign add_z = ad_z_q;

  always @(posedge clk) begin : adder_model
    int rp, zz;
    rp = 2 * ad_r_q + ad_s_q;
    zz = sel_digit(rp);
    ad_r_q <= rp - 4 * zz;
    ad_z_q <= (zz > 0) ? 2'b10 : ((zz < 0) ? 2'b01 : 2'b00);
    ad_s_q <= sd(axp, axm) + sd(ayp, aym);
  end

  typedef struct {
    logic [N:0] z1;
    logic [N:0] z0;
    int         val;
  } exp_t;

  exp_t sb[$];

  function automatic exp_t model(input logic [N-1:0] p1, m1, p2, m2);
    exp_t e;
    int r, rp, z, s;
    e.z1 = '0; e.z0 = '0; e.val = 0; r = 0;
    for (int k = 1; k <= N + 2; k++) begin
      s = 0;
      if (k <= N) begin
        s = sd(p1[N-k], m1[N-k]) + sd(p2[N-k], m2[N-k]);
        e.val += s * (1 << (N - k));
      end
      rp = 2 * r + s;
      z  = sel_digit(rp);
      r  = rp - 4 * z;
      if (k >= 2) begin
        e.z1[N-(k-2)] = (z > 0);
        e.z0[N-(k-2)] = (z < 0);
      end
    end
    return e;
  endfunction

  // Numeric value of a result, scaled by 2^N.
  function automatic int res_value(input logic [N:0] z1, input logic [N:0] z0);
    int v;
    v = 0;
    for (int j = 0; j <= N; j++) v += sd(z1[N-j], z0[N-j]) * (1 << (N - j));
    return v;
  endfunction

  int nb, first_busy, idle_busy, add_seen, timed_out;

  task automatic drive_run(input logic [N-1:0] p1, m1, p2, m2, input bit hold, input bit scramble);
    @(negedge clk);
    idle_busy = int'(busy);
    start = 1'b1; xp = p1; xm = m1; yp = p2; ym = m2;
    sb.push_back(model(p1, m1, p2, m2));
    @(negedge clk);
    if (!hold) start = 1'b0;
    nb = 0; add_seen = 0; timed_out = 1; first_busy = int'(busy);
    for (int i = 0; i < 100; i++) begin
      if (axp | axm | ayp | aym) add_seen = 1;
      if (done) begin
        timed_out = 0;
        break;
      end
      if (busy) nb++;
      if (scramble) begin
        xp = N'($urandom); xm = N'($urandom); yp = N'($urandom); ym = N'($urandom);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, axp, axm, ayp, aym} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b required 000000", {busy, done, axp, axm, ayp, aym});
    end
    n_checks++;
    if (rz1 !== '0 || rz0 !== '0) begin
      n_fail++; $display("FAIL reset_res: got %h/%h required 0/0", rz1, rz0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_zero_run();
    exp_t e;
    drive_run('0, '0, '0, '0, 1'b0, 1'b0);
    n_checks++;
    if (timed_out != 0 || nb != BUSY_EXP) begin
      n_fail++; $display("FAIL zero_busy_len: got %0d (timeout %0d) required %0d", nb, timed_out, BUSY_EXP);
    end
    n_checks++;
    if (first_busy != 1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL zero_busy_edges: got first %0d at_done %b required 1 0", first_busy, busy);
    end
    n_checks++;
    if (add_seen != 0) begin
      n_fail++; $display("FAIL zero_add_quiet: got nonzero add digit required all zero");
    end
    e = sb.pop_front();
    n_checks++;
    if (rz1 !== e.z1 || rz0 !== e.z0) begin
      n_fail++; $display("FAIL zero_result: got %h/%h required %h/%h", rz1, rz0, e.z1, e.z0);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL done_pulse_width: got done=%b one cycle later required 0", done);
    end
  endtask

  task automatic test_directed_and_random();
    exp_t e;
    logic [N-1:0] p1, m1, p2, m2;
    for (int t = 0; t <= 500; t++) begin
      if (t == 0) begin
        p1 = 8'hFF; m1 = '0; p2 = 8'h80; m2 = '0;
      end else begin
        p1 = N'($urandom); m1 = N'($urandom); p2 = N'($urandom); m2 = N'($urandom);
      end
      drive_run(p1, m1, p2, m2, 1'b0, 1'b0);
      e = sb.pop_front();
      n_checks++;
      if (timed_out != 0 || nb != BUSY_EXP) begin
        n_fail++; $display("FAIL run%0d_busy_len: got %0d (timeout %0d) required %0d", t, nb, timed_out, BUSY_EXP);
      end
      n_checks++;
      if (rz1 !== e.z1 || rz0 !== e.z0) begin
        n_fail++; $display("FAIL run%0d_result: got %h/%h required %h/%h", t, rz1, rz0, e.z1, e.z0);
      end
      n_checks++;
      if (res_value(rz1, rz0) != e.val) begin
        n_fail++; $display("FAIL run%0d_value: got %0d required %0d", t, res_value(rz1, rz0), e.val);
      end
    end
  endtask

  task automatic test_start_held();
    exp_t e;
    for (int r = 0; r < 2; r++) begin
      drive_run(8'hA5, 8'h0C, 8'h3C, 8'h81, 1'b1, 1'b0);
      e = sb.pop_front();
      n_checks++;
      if (timed_out != 0 || nb != BUSY_EXP || first_busy != 1) begin
        n_fail++; $display("FAIL held%0d_busy: got %0d first %0d (timeout %0d) required %0d first 1", r, nb, first_busy, timed_out, BUSY_EXP);
      end
      n_checks++;
      if (rz1 !== e.z1 || rz0 !== e.z0) begin
        n_fail++; $display("FAIL held%0d_result: got %h/%h required %h/%h", r, rz1, rz0, e.z1, e.z0);
      end
    end
    n_checks++;
    if (idle_busy != 0) begin
      n_fail++; $display("FAIL held_idle_gap: got busy=%0d in gap cycle required 0", idle_busy);
    end
    start = 1'b0;
    repeat (2) begin
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) begin
        n_fail++; $display("FAIL held_release: got busy=%b after start drop required 0", busy);
      end
    end
  endtask

  task automatic test_operand_change();
    exp_t e;
    for (int r = 0; r < 3; r++) begin
      drive_run(N'($urandom), N'($urandom), N'($urandom), N'($urandom), 1'b0, 1'b1);
      e = sb.pop_front();
      n_checks++;
      if (timed_out != 0 || rz1 !== e.z1 || rz0 !== e.z0) begin
        n_fail++; $display("FAIL scramble%0d_result: got %h/%h (timeout %0d) required %h/%h", r, rz1, rz0, timed_out, e.z1, e.z0);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    exp_t e;
    int bad;
    e = model(8'hFF, '0, 8'h80, '0);
    @(negedge clk);
    start = 1'b1; xp = 8'hFF; xm = '0; yp = 8'h80; ym = '0;
    @(negedge clk);
    start = 1'b0;
    repeat (LAT + 5) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || rz1[1:0] !== e.z1[N -: 2] || rz0[1:0] !== e.z0[N -: 2]) begin
      n_fail++; $display("FAIL pre_abort: got busy=%b low %b/%b required 1 %b/%b", busy, rz1[1:0], rz0[1:0], e.z1[N -: 2], e.z0[N -: 2]);
    end
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, axp, axm, ayp, aym} !== 6'b0 || rz1 !== '0 || rz0 !== '0) begin
      n_fail++; $display("FAIL abort_clear: got ctrl %b res %h/%h required all zero", {busy, done, axp, axm, ayp, aym}, rz1, rz0);
    end
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) bad = 1;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL abort_quiet: got done/busy after abort required none");
    end
    drive_run(N'($urandom), N'($urandom), N'($urandom), N'($urandom), 1'b0, 1'b0);
    e = sb.pop_front();
    n_checks++;
    if (timed_out != 0 || nb != BUSY_EXP) begin
      n_fail++; $display("FAIL rerun_busy_len: got %0d (timeout %0d) required %0d", nb, timed_out, BUSY_EXP);
    end
    n_checks++;
    if (rz1 !== e.z1 || rz0 !== e.z0) begin
      n_fail++; $display("FAIL rerun_result: got %h/%h required %h/%h", rz1, rz0, e.z1, e.z0);
    end
  endtask

  initial begin
    test_reset();
    test_zero_run();
    test_directed_and_random();
    test_start_held();
    test_operand_change();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
